axis_downsizer: RTL and testbench



---
 rtl/axis_downsizer_if.sv | 14 +
 rtl/axis_downsizer.sv | 120 ++++++++++++
 tb/tb_axis_downsizer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_downsizer_if.sv
// rtl/axis_downsizer_if.sv - AXI-Stream beat bundle (valid/ready/last/data/keep).
interface axis_downsizer_if #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = 4
) ();
  logic              valid;
  logic              ready;
  logic              last;
  logic [DATA_W-1:0] data;
  logic [KEEP_W-1:0] keep;

  modport master (output valid, last, data, keep, input ready);
  modport slave  (input valid, last, data, keep, output ready);
endinterface

// File: rtl/axis_downsizer.sv
// rtl/axis_downsizer.sv - AXIS width down-converter that skips all-empty keep groups.
module axis_downsizer #(
  parameter int WORD_WIDTH    = 16,
  parameter int BUS_WIDTH_IN  = 64,
  parameter int BUS_WIDTH_OUT = 16
) (
  input  logic               aclk,
  input  logic               aresetn,
  axis_downsizer_if.slave    s,
  axis_downsizer_if.master   m
);
  localparam int WPB_IN  = BUS_WIDTH_IN / WORD_WIDTH;
  localparam int WPB_OUT = BUS_WIDTH_OUT / WORD_WIDTH;
  localparam int R       = BUS_WIDTH_IN / BUS_WIDTH_OUT;
  localparam int IDX_W   = (R > 1) ? $clog2(R) : 1;

  logic [BUS_WIDTH_IN-1:0] data_q, data_d;
  logic [WPB_IN-1:0]       keep_q, keep_d;
  logic                    last_q, last_d;
  logic                    full_q, full_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    en_q;

  logic [R-1:0]            ne_q, ne_s;
  logic                    nxt_found, first_found;
  logic [IDX_W-1:0]        nxt_idx, first_idx;
  logic [BUS_WIDTH_OUT-1:0] m_data_w;
  logic [WPB_OUT-1:0]      m_keep_w;
  logic                    s_ready_w, s_hs, m_hs;

  always_comb begin
    ne_q = '0;
    ne_s = '0;
    for (int g = 0; g < R; g++) begin
      ne_q[g] = |keep_q[g*WPB_OUT +: WPB_OUT];
      ne_s[g] = |s.keep[g*WPB_OUT +: WPB_OUT];
    end
  end

  // Descending scan so the last hit is the lowest qualifying group.
  always_comb begin
    nxt_found   = 1'b0;
    nxt_idx     = '0;
    first_found = 1'b0;
    first_idx   = '0;
    for (int g = R - 1; g >= 0; g--) begin
      if (ne_q[g] && (g > int'(idx_q))) begin
        nxt_found = 1'b1;
        nxt_idx   = IDX_W'(g);
      end
      if (ne_s[g]) begin
        first_found = 1'b1;
        first_idx   = IDX_W'(g);
      end
    end
  end

  always_comb begin
    m_data_w = '0;
    m_keep_w = '0;
    for (int g = 0; g < R; g++) begin
      if (idx_q == IDX_W'(g)) begin
        m_data_w = data_q[g*BUS_WIDTH_OUT +: BUS_WIDTH_OUT];
        m_keep_w = keep_q[g*WPB_OUT +: WPB_OUT];
      end
    end
  end

  assign s_ready_w = en_q && (!full_q || (m.ready && !nxt_found));
  assign s.ready   = s_ready_w;
  assign s_hs      = s.valid && s_ready_w;
  assign m_hs      = full_q && m.ready;

  assign m.valid = full_q;
  assign m.data  = m_data_w;
  assign m.keep  = m_keep_w;
  assign m.last  = last_q && !nxt_found;

  always_comb begin
    data_d = data_q;
    keep_d = keep_q;
    last_d = last_q;
    full_d = full_q;
    idx_d  = idx_q;
    if (m_hs) begin
      if (nxt_found) idx_d = nxt_idx;
      else           full_d = 1'b0;
    end
    // A load wins over finishing the previous beat; empty non-last beats vanish.
    if (s_hs) begin
      if (first_found || s.last) begin
        data_d = s.data;
        keep_d = s.keep;
        last_d = s.last;
        full_d = 1'b1;
        idx_d  = first_found ? first_idx : '0;
      end else begin
        full_d = 1'b0;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      data_q <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
      full_q <= 1'b0;
      idx_q  <= '0;
      en_q   <= 1'b0;
    end else begin
      data_q <= data_d;
      keep_q <= keep_d;
      last_q <= last_d;
      full_q <= full_d;
      idx_q  <= idx_d;
      en_q   <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axis_downsizer.sv
// tb/tb_axis_downsizer.sv - directed and stress bench for axis_downsizer (R=4 and R=2).
module tb_axis_downsizer;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axis_downsizer_if #(.DATA_W(64), .KEEP_W(4)) s1 ();
  axis_downsizer_if #(.DATA_W(16), .KEEP_W(1)) m1 ();
  axis_downsizer_if #(.DATA_W(64), .KEEP_W(4)) s2 ();
  axis_downsizer_if #(.DATA_W(32), .KEEP_W(2)) m2 ();

  axis_downsizer #(.WORD_WIDTH(16), .BUS_WIDTH_IN(64), .BUS_WIDTH_OUT(16)) dut (
    .aclk(aclk), .aresetn(aresetn), .s(s1), .m(m1));
  axis_downsizer #(.WORD_WIDTH(16), .BUS_WIDTH_IN(64), .BUS_WIDTH_OUT(32)) dut2 (
    .aclk(aclk), .aresetn(aresetn), .s(s2), .m(m2));

  int n_cmp = 0;
  int n_fail = 0;
  int n_last = 0;
  bit stress_en = 1'b0;
  bit man_ready = 1'b1;
  bit rnd_ready = 1'b0;

  assign m1.ready = stress_en ? rnd_ready : man_ready;
  assign m2.ready = 1'b1;

  always @(posedge aclk) begin
    #1 rnd_ready = ($urandom_range(99) < 20);
  end

  typedef struct {
    logic [15:0] d;
    logic        k;
    logic        l;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [63:0]       data;
    logic [3:0]        keep;
    logic              last;
    int                n;
    int                low;
    logic [3:0][15:0]  ew;
    logic [3:0]        ek;
    logic [3:0]        el;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int w0, input int w1, input int w2, input int w3);
    return {16'(w3), 16'(w2), 16'(w1), 16'(w0)};
  endfunction

  // Output scoreboard plus hold-stable check on the narrow side.
  bit stall = 1'b0;
  logic [15:0] pd;
  logic pk, pl;
  always @(negedge aclk) begin
    exp_t e;
    if (!aresetn) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("stable_data", 64'(m1.data), 64'(pd));
        chk("stable_keep", 64'(m1.keep), 64'(pk));
        chk("stable_last", 64'(m1.last), 64'(pl));
      end
      if (m1.valid && m1.ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL extra_beat act=%h exp=none", m1.data);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 64'(m1.data), 64'(e.d));
          chk("out_keep", 64'(m1.keep), 64'(e.k));
          chk("out_last", 64'(m1.last), 64'(e.l));
        end
        if (m1.last) n_last++;
      end
      stall = m1.valid && !m1.ready;
      pd = m1.data;
      pk = m1.keep[0];
      pl = m1.last;
    end
  end

  task automatic send(input logic [63:0] d, input logic [3:0] k, input logic l, input bit rnd);
    bit ok = 1'b0;
    if (rnd) begin
      while ($urandom_range(99) >= 5) begin
        @(posedge aclk); #1;
      end
    end
    s1.valid = 1'b1; s1.data = d; s1.keep = k; s1.last = l;
    for (int t = 0; t < 2000; t++) begin
      @(negedge aclk);
      if (s1.ready) begin ok = 1'b1; break; end
    end
    @(posedge aclk); #1;
    s1.valid = 1'b0;
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout act=stalled exp=accepted");
    end
  endtask

  task automatic drain(input int lim, input string nm);
    for (int t = 0; t < lim; t++) begin
      if (exp_q.size() == 0) break;
      @(negedge aclk);
    end
    chk(nm, 64'(exp_q.size()), 64'd0);
    @(posedge aclk); #1;
  endtask

  task automatic push(input logic [15:0] d, input logic k, input logic l);
    exp_t e;
    e.d = d; e.k = k; e.l = l;
    exp_q.push_back(e);
  endtask

  initial begin
    int low, outs, first, last_cyc, cyc, b;
    bit acc;
    logic [31:0] ew2;

    vecs[0] = '{mk(0,1,2,3),     4'b1111, 1'b1, 4, 3, {16'd3, 16'd2, 16'd1, 16'd0},  4'b1111, 4'b1000};
    vecs[1] = '{mk(10,11,12,13), 4'b0101, 1'b1, 2, 1, {16'd0, 16'd0, 16'd12, 16'd10}, 4'b0011, 4'b0010};
    vecs[2] = '{mk(20,21,22,23), 4'b0000, 1'b0, 0, 0, {16'd0, 16'd0, 16'd0, 16'd0},   4'b0000, 4'b0000};
    vecs[3] = '{mk(5,6,7,8),     4'b0001, 1'b1, 1, 0, {16'd0, 16'd0, 16'd0, 16'd5},   4'b0001, 4'b0001};
    vecs[4] = '{mk(40,41,42,43), 4'b0000, 1'b1, 1, 0, {16'd0, 16'd0, 16'd0, 16'd40},  4'b0000, 4'b0001};
    vecs[5] = '{mk(50,51,52,53), 4'b1010, 1'b0, 2, 1, {16'd0, 16'd0, 16'd53, 16'd51}, 4'b0011, 4'b0000};
    vecs[6] = '{mk(60,61,62,63), 4'b1000, 1'b1, 1, 0, {16'd0, 16'd0, 16'd0, 16'd63},  4'b0001, 4'b0001};
    vecs[7] = '{mk(70,71,72,73), 4'b0110, 1'b1, 2, 1, {16'd0, 16'd0, 16'd72, 16'd71}, 4'b0011, 4'b0010};

    s1.valid = 1'b0; s1.data = '0; s1.keep = '0; s1.last = 1'b0;
    s2.valid = 1'b0; s2.data = '0; s2.keep = '0; s2.last = 1'b0;

    repeat (3) @(posedge aclk);
    #1;
    chk("rst_m_valid", 64'(m1.valid), 64'd0);
    chk("rst_m_last",  64'(m1.last),  64'd0);
    chk("rst_m_data",  64'(m1.data),  64'd0);
    chk("rst_m_keep",  64'(m1.keep),  64'd0);
    chk("rst_s_ready", 64'(s1.ready), 64'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("rel_s_ready_low", 64'(s1.ready), 64'd0);
    @(posedge aclk); #1;
    chk("rel_s_ready_high", 64'(s1.ready), 64'd1);

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < vecs[v].n; i++) push(vecs[v].ew[i], vecs[v].ek[i], vecs[v].el[i]);
      send(vecs[v].data, vecs[v].keep, vecs[v].last, 1'b0);
      low = 0;
      for (int t = 0; t < 10; t++) begin
        @(negedge aclk);
        if (t == 0) chk($sformatf("v%0d_latency", v), 64'(m1.valid), 64'(vecs[v].n > 0));
        if (s1.ready) break;
        low++;
      end
      chk($sformatf("v%0d_ready_low", v), 64'(low), 64'(vecs[v].low));
      drain(20, $sformatf("v%0d_drain", v));
    end

    // Reset with two of four groups already delivered.
    for (int i = 0; i < 4; i++) push(16'(100 + i), 1'b1, i == 3);
    send(mk(100,101,102,103), 4'b1111, 1'b1, 1'b0);
    @(posedge aclk); @(posedge aclk); #1;
    aresetn = 1'b0;
    #1;
    chk("midrst_m_valid", 64'(m1.valid), 64'd0);
    chk("midrst_m_data",  64'(m1.data),  64'd0);
    chk("midrst_m_keep",  64'(m1.keep),  64'd0);
    chk("midrst_q_left",  64'(exp_q.size()), 64'd2);
    exp_q.delete();
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    chk("midrst_ready_low", 64'(s1.ready), 64'd0);
    @(posedge aclk); #1;
    chk("midrst_ready_high", 64'(s1.ready), 64'd1);
    for (int i = 0; i < 4; i++) push(16'(200 + i), 1'b1, i == 3);
    send(mk(200,201,202,203), 4'b1111, 1'b1, 1'b0);
    drain(20, "midrst_drain");

    // Random source/sink stream of words 0..201.
    n_last = 0;
    stress_en = 1'b1;
    for (int bb = 0; bb <= 50; bb++) begin
      for (int w = 0; w < 4; w++)
        if (bb < 50 || w < 2) push(16'(4*bb + w), 1'b1, (bb == 50) && (w == 1));
      send(mk(4*bb, 4*bb+1, 4*bb+2, 4*bb+3), (bb == 50) ? 4'b0011 : 4'b1111, bb == 50, 1'b1);
    end
    drain(3000, "stress_drain");
    stress_en = 1'b0;
    chk("stress_last_count", 64'(n_last), 64'd1);

    // R=2 throughput: 8 dense beats, s_valid and m_ready held high.
    b = 0; outs = 0; first = -1; last_cyc = -1; cyc = 0;
    s2.valid = 1'b1; s2.data = mk(0,1,2,3); s2.keep = 4'b1111; s2.last = 1'b0;
    while (outs < 16 && cyc < 100) begin
      @(negedge aclk);
      if (m2.valid) begin
        ew2 = {16'(2*outs + 1), 16'(2*outs)};
        chk($sformatf("r2_data%0d", outs), 64'(m2.data), 64'(ew2));
        chk($sformatf("r2_keep%0d", outs), 64'(m2.keep), 64'd3);
        chk($sformatf("r2_last%0d", outs), 64'(m2.last), 64'(outs == 15));
        if (first < 0) first = cyc;
        last_cyc = cyc;
        outs++;
      end
      acc = s2.valid && s2.ready;
      @(posedge aclk); #1;
      if (acc) begin
        b++;
        if (b == 8) s2.valid = 1'b0;
        else begin
          s2.data = mk(4*b, 4*b+1, 4*b+2, 4*b+3);
          s2.last = (b == 7);
        end
      end
      cyc++;
    end
    chk("r2_out_count", 64'(outs), 64'd16);
    chk("r2_no_bubble", 64'(last_cyc - first), 64'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
